// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for the EX stage (DIV/DIVU -> HI/LO).
// Produces {remainder, quotient}; stalls the pipeline while the operation is in flight.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DIV_ZERO, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic                  qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*DATA_W-1:0]   res_q, res_d;
  logic                  rdy_q, rdy_d;

  logic [DATA_W-1:0]     a_abs, b_abs;
  logic [DATA_W:0]       rem_sh;
  logic                  ge;
  logic [DATA_W-1:0]     rem_nx, quo_nx, rem_fix, quo_fix;
  logic                  last;

  // Magnitudes only for DIV; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  assign a_abs = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
  assign b_abs = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

  // One restoring step: 33-bit shifted remainder against the zero-extended divisor.
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign ge      = (rem_sh >= {1'b0, dvsr_q});
  assign rem_nx  = ge ? DATA_W'(rem_sh - {1'b0, dvsr_q}) : rem_sh[DATA_W-1:0];
  assign quo_nx  = {quo_q[DATA_W-2:0], ge};
  assign quo_fix = qneg_q ? -quo_nx : quo_nx;
  assign rem_fix = rneg_q ? -rem_nx : rem_nx;
  assign last    = (cnt_q == CNT_W'(DATA_W-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (divisor_i == '0) begin
            state_d = DIV_ZERO;
          end else begin
            state_d = BUSY;
            rem_d   = '0;
            quo_d   = a_abs;
            dvsr_d  = b_abs;
            qneg_d  = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
            rneg_d  = signed_i & dividend_i[DATA_W-1];
            cnt_d   = '0;
          end
        end
      end
      DIV_ZERO: begin
        if (annul_i) begin
          state_d = IDLE;
          rdy_d   = 1'b0;
        end else begin
          state_d = DONE;
          res_d   = '0;
          rdy_d   = 1'b1;
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
          rdy_d   = 1'b0;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            state_d = DONE;
            res_d   = {rem_fix, quo_fix};
            rdy_d   = 1'b1;
          end
        end
      end
      DONE: begin
        // Hold the result until EX drops its request so the same op is never re-issued.
        if (annul_i || !start_i) begin
          state_d = IDLE;
          rdy_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  assign result_o    = res_q;
  assign ready_o     = rdy_q;
  assign stall_req_o = ~rst & (((state_q == IDLE) & start_i & ~annul_i) |
                               (state_q == DIV_ZERO) | (state_q == BUSY));

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized + directed bench for div_ctrl against a transaction-level latency/result model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start_i, signed_i, annul_i;
  logic [31:0] dividend_i, divisor_i;
  logic [63:0] result_o;
  logic        ready_o, stall_req_o;

  int nerr = 0;
  int nchk = 0;

  div_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for a request, 1 = operation in flight, 2 = result presented.
  int          m_ph, m_left;
  logic        m_ready;
  logic [63:0] m_res, m_pend;
  bit          mv = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0; m_left <= 0; m_ready <= 1'b0; m_res <= 64'd0; mv <= 1'b1;
    end else begin
      case (m_ph)
        0: if (start_i && !annul_i) begin
          m_ph   <= 1;
          m_pend <= ref_div(signed_i, dividend_i, divisor_i);
          m_left <= (divisor_i == 32'd0) ? 1 : 32;
        end
        1: if (annul_i) begin
          m_ph <= 0; m_ready <= 1'b0;
        end else if (m_left == 1) begin
          m_ph <= 2; m_ready <= 1'b1; m_res <= m_pend;
        end else begin
          m_left <= m_left - 1;
        end
        default: if (annul_i || !start_i) begin
          m_ph <= 0; m_ready <= 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("ready", {63'd0, ready_o}, {63'd0, m_ready});
      chk("result", result_o, m_res);
      chk("stall", {63'd0, stall_req_o},
          {63'd0, !rst && ((m_ph == 0 && start_i && !annul_i) || m_ph == 1)});
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int hold, output int lat);
    bit got = 1'b0;
    lat = 0;
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1);
      lat++;
      dividend_i = $urandom; divisor_i = $urandom;  // must be ignored after load
      if (ready_o) got = 1'b1;
    end
    if (!got) begin
      nerr++; nchk++;
      $display("FAIL op_timeout: ready_o never rose for %h / %h", a, b);
    end else begin
      chk("op_result", result_o, exp);
    end
    step(hold);
    start_i = 1'b0;
    step(1);
    chk("ready_drop", {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = 32'd0; divisor_i = 32'd0;
    step(2);
    chk("rst_result", result_o, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_stall", {63'd0, stall_req_o}, 64'd0);
    rst = 1'b0;
    step(1);

    chk("model_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    chk("model_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model_min_m1", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'd0, 32'h80000000});

    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'h0000000E}, 0, lat);
    chk("lat_divu", lat, 33);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1, lat);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 0, lat);
    run_op(1'b1, 32'd5, 32'd0, 64'd0, 0, lat);
    chk("lat_dz", lat, 2);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 0, lat);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 0, lat);
    run_op(1'b0, 32'd3, 32'hFFFFFFFF, {32'd3, 32'd0}, 5, lat);

    // Annul mid-operation: no result may appear.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    step(11);
    annul_i = 1'b1; start_i = 1'b0;
    step(1);
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (ready_o) seen = 1'b1;
      step(1);
    end
    chk("annul_noready", {63'd0, seen}, 64'd0);
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, lat);
    chk("lat_after_annul", lat, 33);

    // Reset in the middle of a divide.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd12345; divisor_i = 32'd11;
    step(21);
    rst = 1'b1;
    step(1);
    chk("midrst_result", result_o, 64'd0);
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrst_stall", {63'd0, stall_req_o}, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    step(1);

    for (int n = 0; n < 40; n++) begin
      bit sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        3: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
        step($urandom_range(1, 34));
        annul_i = 1'b1;
        step(1);
        annul_i = 1'b0; start_i = 1'b0;
        step(1);
      end else begin
        run_op(sgn, a, b, ref_div(sgn, a, b), $urandom_range(0, 3), lat);
      end
    end

    step(2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Multi-cycle 32-bit divider with controller FSM for the EX stage; executes DIV/DIVU for the HI/LO path.
- Latches operands on a start request, runs a 32-step restoring division, and returns {remainder, quotient}.
- Raises stall_req_o so the pipeline controller freezes IF/ID/EX until the result is ready.
- Accepts annul_i to abort on exception/flush.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  divide request from EX; held high until ready_o seen
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend_i  input  32  dividend (rs)
- divisor_i  input  32  divisor (rt)
- annul_i  input  1  abort current operation (flush/exception)
- result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready_o  output  1  result_o valid
- stall_req_o  output  1  pipeline stall request

Behaviour:
- Reset values:
  - rst=1 at an edge forces IDLE, result_o=0, ready_o=0, counter=0.
  - stall_req_o=0 while rst is high.
  - rst has priority over every other input.
- States: IDLE, DIV_ZERO, BUSY, DONE.
- IDLE:
  - start_i=1, annul_i=0, divisor_i==0 -> DIV_ZERO.
  - start_i=1, annul_i=0, divisor_i!=0 -> BUSY. On the same edge, latch |dividend|, |divisor|, sign of the quotient (dividend[31]^divisor[31]) and sign of the remainder (dividend[31]). Absolute values apply only when signed_i=1, otherwise operands are used raw. Clear the partial remainder and set counter=0.
  - Otherwise stay in IDLE.
- DIV_ZERO: next edge -> DONE with result_o=0 and ready_o=1.
- BUSY:
  - Each edge performs one restoring step: shift {rem, quo} left by 1; if rem_shifted >= divisor, subtract it and set the quotient LSB. Use a 33-bit compare/subtract; no overflow is permitted.
  - Counter increments each step. On the edge where counter==DATA_W-1, the final step completes, sign correction is applied, result_o is written, ready_o=1, and the FSM enters DONE.
  - Load edge E0 -> ready_o high after edge E32, i.e. 32 cycles after load.
- Sign correction (signed_i=1 only):
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0; no trap.
- DONE:
  - result_o and ready_o are held.
  - start_i=0 -> IDLE with ready_o=0 on that edge.
  - start_i=1 -> remain in DONE; no re-issue until start_i drops.
- annul_i:
  - In DIV_ZERO or BUSY: next edge -> IDLE, ready_o=0, result_o unchanged.
  - In IDLE: blocks a new start.
  - In DONE: -> IDLE, ready_o=0.
- stall_req_o (combinational) = (IDLE & start_i & ~annul_i) | DIV_ZERO | BUSY. It is low in DONE so the pipeline advances and captures the result.
- Operand inputs are ignored after the load edge.
- Back-to-back: DONE -> IDLE (start_i low for at least 1 cycle) -> a new start is accepted the following cycle.

Test Plan:
- Unsigned: DIVU 100/7, start at E0 -> stall_req_o high E0..E31, ready_o after E32, result_o = {0x00000002, 0x0000000E}; drop start_i -> IDLE, ready_o=0 next edge.
- Signed: DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: DIV 5/0 -> DIV_ZERO for 1 cycle, ready_o after E1, result_o=0, stall_req_o low in DONE.
- Overflow/edge cases:
  - DIV 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
  - DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
  - DIVU 3/0xFFFFFFFF -> {3, 0}.
- Annul: assert annul_i at BUSY step 10 -> IDLE next edge, ready_o never rises. A following DIVU 9/3 completes with {0, 3} after 32 cycles.
- Reset/hold:
  - rst at BUSY step 20 -> all outputs 0 and IDLE next edge.
  - Hold start_i high in DONE for 5 cycles -> result_o stable, ready_o stays 1, no restart.
